// File: rtl/frame_pkg.sv
// Shared types for the 2x2-block frame memory write path.
package frame_pkg;
  localparam int PIX_BITS     = 24;
  localparam int PIX_PER_WORD = 4;

  typedef logic [PIX_BITS-1:0]              pixel_t;
  typedef logic [PIX_BITS*PIX_PER_WORD-1:0] quad_t;
  typedef logic [2*PIX_BITS-1:0]            lbuf_pair_t;

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;
endpackage

// File: rtl/frame_line_buf.sv
// Single-port synchronous line buffer holding one even row as pixel pairs.
// Read data appears one cycle after an enabled read and holds until the next read.
module frame_line_buf
  import frame_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int AW    = 8
) (
  input  logic             CLK,
  input  logic             EN,
  input  logic             WE,
  input  logic [AW-1:0]    ADDR,
  input  lbuf_pair_t       DIN,
  output lbuf_pair_t       DOUT
);

  lbuf_pair_t mem [DEPTH];

  // Storage write or registered read; no reset on storage or read data.
  always_ff @(posedge CLK) begin
    if (EN) begin
      if (WE) mem[ADDR] <= DIN;
      else    DOUT      <= mem[ADDR];
    end
  end

endmodule

// File: rtl/frame_wr_packer.sv
// Packs a 24bpp raster stream into 2x2 quads and writes them to the frame memory.
// Even rows are parked in the line buffer; odd rows complete the quads.
// Optional macro FRMWR_SOF_RESYNC_EN: a SOF pixel mid-frame restarts the frame.
module frame_wr_packer
  import frame_pkg::*;
#(
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_DEPTH = 512*512/4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  PIX_VLD,
  output logic                  PIX_RDY,
  input  logic                  PIX_SOF,
  input  logic [PIX_BITS-1:0]   PIX_DATA,
  output logic                  MEM_CSN,
  output logic                  MEM_WEN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DIN,
  output logic                  FRAME_DONE
);

  localparam int COL_W = $clog2(HRES);
  localparam int ROW_W = $clog2(VRES);
  localparam int LB_AW = COL_W - 1;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  pixel_t                hold_q, hold_d;
  logic                  rdy_q, rdy_d;
  logic                  csn_q, csn_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  done_q, done_d;

  logic                  xfer, sof_start, last_col, last_row;
  logic                  lb_en, lb_we;
  logic [LB_AW-1:0]      lb_addr;
  lbuf_pair_t            lb_din, lb_dout;
  quad_t                 quad;

  assign xfer     = PIX_VLD && rdy_q;
  assign last_col = (col_q == COL_W'(HRES - 1));
  assign last_row = (row_q == ROW_W'(VRES - 1));
  assign quad     = {lb_dout, hold_q, PIX_DATA};

`ifdef FRMWR_SOF_RESYNC_EN
  assign sof_start = xfer && PIX_SOF;
`else
  assign sof_start = xfer && PIX_SOF && (state_q == IDLE);
`endif

  frame_line_buf #(
    .DEPTH (HRES/2),
    .AW    (LB_AW)
  ) u_lbuf (
    .CLK  (CLK),
    .EN   (lb_en),
    .WE   (lb_we),
    .ADDR (lb_addr),
    .DIN  (lb_din),
    .DOUT (lb_dout)
  );

  // Next-state, counter, line-buffer access and registered-output decode.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wcnt_d  = wcnt_q;
    hold_d  = hold_q;
    csn_d   = 1'b1;
    wen_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = 1'b0;
    lb_en   = 1'b0;
    lb_we   = 1'b0;
    lb_addr = col_q[COL_W-1:1];
    lb_din  = {hold_q, PIX_DATA};

    if (sof_start) begin
      // The SOF pixel is (0,0); any partial quad in flight is dropped.
      hold_d  = PIX_DATA;
      col_d   = COL_W'(1);
      row_d   = '0;
      wcnt_d  = '0;
      state_d = EVEN;
    end else begin
      case (state_q)
        EVEN: begin
          if (xfer) begin
            if (!col_q[0]) hold_d = PIX_DATA;
            else begin
              lb_en = 1'b1;
              lb_we = 1'b1;
            end
            if (last_col) begin
              col_d   = '0;
              row_d   = row_q + ROW_W'(1);
              state_d = ODD;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        ODD: begin
          if (xfer) begin
            if (!col_q[0]) begin
              hold_d = PIX_DATA;
              lb_en  = 1'b1;
            end else begin
              csn_d  = 1'b0;
              wen_d  = 1'b0;
              addr_d = wcnt_q;
              din_d  = quad;
              wcnt_d = wcnt_q + ADDR_WIDTH'(1);
            end
            if (last_col) begin
              col_d = '0;
              if (last_row) begin
                row_d   = '0;
                done_d  = 1'b1;
                state_d = DONE;
              end else begin
                row_d   = row_q + ROW_W'(1);
                state_d = EVEN;
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end

    rdy_d = (state_d != DONE);
  end

  // Control state, counters and all registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wcnt_q  <= '0;
      rdy_q   <= 1'b0;
      csn_q   <= 1'b1;
      wen_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wcnt_q  <= wcnt_d;
      rdy_q   <= rdy_d;
      csn_q   <= csn_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  // Held even-column pixel; pure data, so no reset.
  always_ff @(posedge CLK) begin
    hold_q <= hold_d;
  end

  assign PIX_RDY    = rdy_q;
  assign MEM_CSN    = csn_q;
  assign MEM_WEN    = wen_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_DIN    = din_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_frame_wr_packer.sv
// Scoreboard bench for frame_wr_packer on a reduced 40x12 frame.
module tb_frame_wr_packer;
  localparam int H  = 40;
  localparam int V  = 12;
  localparam int AW = 16;
  localparam int NW = H*V/4;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          PIX_VLD = 1'b0;
  logic          PIX_SOF = 1'b0;
  logic [23:0]   PIX_DATA = '0;
  logic          PIX_RDY, MEM_CSN, MEM_WEN, FRAME_DONE;
  logic [AW-1:0] MEM_ADDR;
  logic [95:0]   MEM_DIN;

  frame_wr_packer #(.HRES(H), .VRES(V)) dut (
    .CLK(CLK), .RSTN(RSTN), .PIX_VLD(PIX_VLD), .PIX_RDY(PIX_RDY),
    .PIX_SOF(PIX_SOF), .PIX_DATA(PIX_DATA), .MEM_CSN(MEM_CSN),
    .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [95:0]   din;
    logic          last;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         wr_log[$];
  wr_t         ref_log[$];
  wr_t         mon_got, mon_exp;
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          d0;
  bit          prev_wr = 1'b0;
  logic [23:0] img [H*V];
  bit          in_frame = 1'b0;
  int          idx = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: track the pixel index within the frame and emit a
  // write whenever the bottom-right pixel of a 2x2 block is accepted.
  task automatic model_accept(input logic [23:0] d, input logic sof);
    int  r, c;
    bit  rs;
    wr_t w;
`ifdef FRMWR_SOF_RESYNC_EN
    rs = 1'b1;
`else
    rs = 1'b0;
`endif
    if (sof && (!in_frame || rs)) begin
      in_frame = 1'b1;
      idx = 0;
    end else if (!in_frame) begin
      return;
    end
    r = idx / H;
    c = idx % H;
    img[idx] = d;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      w.addr = AW'((r/2)*(H/2) + c/2);
      w.din  = {img[idx-H-1], img[idx-H], img[idx-1], d};
      w.last = (idx == H*V-1);
      exp_q.push_back(w);
    end
    idx++;
    if (idx == H*V) in_frame = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the pixel is taken.
  task automatic send_pix(input logic [23:0] d, input logic sof, input int gap);
    int tries;
    while (gap > 0 && $urandom_range(0, 99) < gap) begin
      PIX_VLD = 1'b0; PIX_SOF = 1'b0; PIX_DATA = 24'($urandom);
      @(negedge CLK);
    end
    PIX_VLD = 1'b1; PIX_SOF = sof; PIX_DATA = d;
    tries = 0;
    while (!PIX_RDY && tries < 8) begin
      @(negedge CLK);
      tries++;
    end
    if (!PIX_RDY) begin
      errors++; checks++;
      $display("FAIL rdy_timeout: PIX_RDY %0b after %0d cycles, required 1", PIX_RDY, tries);
    end else begin
      model_accept(d, sof);
      @(negedge CLK);
    end
    PIX_VLD = 1'b0; PIX_SOF = 1'b0;
  endtask

  function automatic logic [23:0] pix_val(input int kind, input int r, input int c);
    logic [23:0] v;
    v = 24'((r << 12) | c);
    if (kind == 1) v = 24'($urandom);
    if (kind == 2 && r < 2 && c < 2)
      v = 24'h111111 * 24'(1 + 2*r + c);
    return v;
  endfunction

  task automatic send_frame(input int kind, input int gap, input int first, input int count);
    for (int i = first; i < first + count; i++)
      send_pix(pix_val(kind, i / H, i % H), (i == 0), gap);
  endtask

  task automatic idle(input int n);
    PIX_VLD = 1'b0; PIX_SOF = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},  128'(PIX_RDY),    128'(0));
    check({tag, "_csn"},  128'(MEM_CSN),    128'(1));
    check({tag, "_wen"},  128'(MEM_WEN),    128'(1));
    check({tag, "_addr"}, 128'(MEM_ADDR),   128'(0));
    check({tag, "_din"},  128'(MEM_DIN),    128'(0));
    check({tag, "_done"}, 128'(FRAME_DONE), 128'(0));
  endtask

  // Monitor: every write strobe pops the next expected word.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (!MEM_CSN) begin
        check("wen_with_csn", 128'(MEM_WEN), 128'(0));
        check("strobe_width", 128'(prev_wr), 128'(0));
        mon_got.addr = MEM_ADDR;
        mon_got.din  = MEM_DIN;
        mon_got.last = FRAME_DONE;
        wr_log.push_back(mon_got);
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_write: addr %0h din %0h, no write expected", MEM_ADDR, MEM_DIN);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wr_addr", 128'(MEM_ADDR), 128'(mon_exp.addr));
          check("wr_din", 128'(MEM_DIN), 128'(mon_exp.din));
          check("wr_frame_done", 128'(FRAME_DONE), 128'(mon_exp.last));
        end
      end else begin
        if (!MEM_WEN) begin
          errors++; checks++;
          $display("FAIL wen_without_csn: MEM_WEN %0b, required 1", MEM_WEN);
        end
        if (FRAME_DONE) begin
          errors++; checks++;
          $display("FAIL stray_frame_done: FRAME_DONE %0b without write, required 0", FRAME_DONE);
        end
      end
      if (FRAME_DONE) done_cnt++;
      prev_wr = !MEM_CSN;
    end else begin
      prev_wr = 1'b0;
    end
  end

  initial begin
    // Reset values
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    check("rdy_after_reset", 128'(PIX_RDY), 128'(1));

    // Garbage before any SOF
    for (int i = 0; i < 10; i++) send_pix(24'($urandom), 1'b0, 0);
    idle(3);
    check("garbage_writes", 128'(wr_log.size()), 128'(0));

    // Frame with the known first quad
    d0 = done_cnt;
    send_frame(2, 0, 0, H*V);
    idle(4);
    check("f1_writes", 128'(wr_log.size()), 128'(NW));
    check("f1_first", 128'({wr_log[0].addr, wr_log[0].din}),
          128'({16'h0, 96'h111111222222333333444444}));
    check("f1_last_addr", 128'(wr_log[NW-1].addr), 128'(NW-1));
    check("f1_done_count", 128'(done_cnt), 128'(d0 + 1));

    // Coordinate frame, continuous valid
    wr_log.delete();
    send_frame(0, 0, 0, H*V);
    idle(4);
    ref_log = wr_log;
    check("f2_writes", 128'(wr_log.size()), 128'(NW));
    check("f2_quad_r2c2_addr", 128'(wr_log[H/2+1].addr), 128'(H/2+1));
    check("f2_quad_r2c2_din", 128'(wr_log[H/2+1].din),
          128'({24'h002002, 24'h002003, 24'h003002, 24'h003003}));

    // Same frame with 50% valid gaps must produce the same writes
    wr_log.delete();
    send_frame(0, 50, 0, H*V);
    idle(4);
    check("f3_writes", 128'(wr_log.size()), 128'(NW));
    for (int i = 0; i < wr_log.size() && i < ref_log.size(); i++)
      check("f3_same_as_continuous", 128'(wr_log[i]), 128'(ref_log[i]));

    // Random data with random gaps
    d0 = done_cnt;
    send_frame(1, 30, 0, H*V);
    idle(4);
    check("f4_done_count", 128'(done_cnt), 128'(d0 + 1));

    // Asynchronous reset in the middle of row 7
    send_frame(1, 0, 0, 7*H + 15);
    #2 RSTN = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    in_frame = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    wr_log.delete();
    send_frame(2, 0, 0, H*V);
    idle(4);
    check("f5_writes", 128'(wr_log.size()), 128'(NW));
    check("f5_first", 128'({wr_log[0].addr, wr_log[0].din}),
          128'({16'h0, 96'h111111222222333333444444}));

    // SOF at row 5, col 10
    wr_log.delete();
    d0 = done_cnt;
    send_frame(0, 0, 0, 5*H + 10);
    send_pix(24'hABCDEF, 1'b1, 0);
`ifdef FRMWR_SOF_RESYNC_EN
    send_frame(0, 0, 1, H*V - 1);
    idle(4);
    check("sof_writes", 128'(wr_log.size()), 128'(45 + NW));
    check("sof_next_addr", 128'(wr_log[45].addr), 128'(0));
`else
    send_frame(0, 0, 5*H + 11, H*V - 5*H - 11);
    idle(4);
    check("sof_writes", 128'(wr_log.size()), 128'(NW));
    check("sof_next_addr", 128'(wr_log[45].addr), 128'(45));
`endif
    check("sof_done_count", 128'(done_cnt), 128'(d0 + 1));

    idle(10);
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
